tm_model_loader: RTL and testbench

Streams a trained convolutional Tsetlin machine model (clause masks, then class weights) from a host-side ready/valid word stream into the inference core's configuration write ports. It sits between the host DMA/stream source and the inference top-level. It is the writer for the core's `clause_write`/`bram_addr_a`/`wea` and `weight_write`/`bram_addr_a2`/`wea2` ports. It generates one single-cycle write strobe per accepted stream beat and flags framing errors.

---
 rtl/tm_model_loader_if.sv | 12 +
 rtl/tm_model_loader.sv | 169 ++++++++++++++++
 tb/tb_tm_model_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_model_loader_if.sv
// Host-side model stream: ready/valid word beats with an end-of-model marker.
interface tm_model_loader_if #(
   parameter int DATA_W = 256
) ();
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/tm_model_loader.sv
// Tsetlin machine model loader: streams clause masks then class weights from
// the host stream into the inference core's write ports, one strobe per beat.
module tm_model_loader #(
   parameter int CLAUSEN = 10,
   parameter int CLASSN  = 10,
   parameter int WPC     = 5,
   parameter int DATA_W  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [8:0]        clauses,
   tm_model_loader_if.slave  s,
   output logic              wea,
   output logic [31:0]       bram_addr_a,
   output logic [DATA_W-1:0] clause_write,
   output logic              wea2,
   output logic [31:0]       bram_addr_a2,
   output logic [DATA_W-1:0] weight_write,
   output logic              busy,
   output logic              load_done,
   output logic              err
);

   localparam logic [31:0] NW     = 32'(CLASSN * WPC);
   localparam logic [31:0] CL_MAX = 32'(CLAUSEN);

   typedef enum logic [2:0] {
      IDLE,
      CLAUSE,
      WEIGHT,
      FLUSH,
      ERR
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       k_q, k_d;
   logic [8:0]        n_cl_q, n_cl_d;

   logic              wea_q, wea_d;
   logic              wea2_q, wea2_d;
   logic [31:0]       addr_a_q, addr_a_d;
   logic [31:0]       addr_a2_q, addr_a2_d;
   logic [DATA_W-1:0] cw_q, cw_d;
   logic [DATA_W-1:0] ww_q, ww_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              ready;
   logic              accept;
   logic              start_ok;
   logic              count_ok;
   logic [31:0]       last_cl;

   assign ready    = (state_q == CLAUSE) || (state_q == WEIGHT);
   assign s.s_ready = ready;
   assign accept   = s.s_valid & ready;
   // The completion pulse cycle is still part of the load, so start stays ignored there.
   assign busy     = (state_q == CLAUSE) || (state_q == WEIGHT) || (state_q == FLUSH) || done_q;
   assign start_ok = start && ((state_q == IDLE) || (state_q == ERR)) && !done_q;
   assign count_ok = (clauses != 9'd0) && ({23'd0, clauses} <= CL_MAX);
   assign last_cl  = {23'd0, n_cl_q} - 32'd1;

   assign wea          = wea_q;
   assign wea2         = wea2_q;
   assign bram_addr_a  = addr_a_q;
   assign bram_addr_a2 = addr_a2_q;
   assign clause_write = cw_q;
   assign weight_write = ww_q;
   assign load_done    = done_q;
   assign err          = err_q;

   // State, beat counter and clause count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         n_cl_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         n_cl_q  <= n_cl_d;
      end
   end

   // Next state: phase sequencing, beat counting and framing checks.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      n_cl_d  = n_cl_q;
      case (state_q)
         IDLE, ERR: begin
            if (start_ok) begin
               if (count_ok) begin
                  n_cl_d  = clauses;
                  k_d     = '0;
                  state_d = CLAUSE;
               end else begin
                  state_d = ERR;
               end
            end
         end
         CLAUSE: begin
            if (accept) begin
               if (s.s_last) begin
                  k_d     = '0;
                  state_d = ERR;
               end else if (k_q == last_cl) begin
                  k_d     = '0;
                  state_d = WEIGHT;
               end else begin
                  k_d = k_q + 32'd1;
               end
            end
         end
         WEIGHT: begin
            if (accept) begin
               if (k_q == NW - 32'd1) begin
                  k_d     = '0;
                  state_d = s.s_last ? FLUSH : ERR;
               end else if (s.s_last) begin
                  k_d     = '0;
                  state_d = ERR;
               end else begin
                  k_d = k_q + 32'd1;
               end
            end
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next values: one write strobe per accepted beat, idle addresses all-ones.
   always_comb begin
      wea_d     = (state_q == CLAUSE) && accept;
      wea2_d    = (state_q == WEIGHT) && accept;
      addr_a_d  = wea_d  ? k_q : '1;
      addr_a2_d = wea2_d ? k_q : '1;
      cw_d      = wea_d  ? s.s_data : cw_q;
      ww_d      = wea2_d ? s.s_data : ww_q;
      done_d    = (state_q == FLUSH);
      err_d     = (state_d == ERR);
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wea_q     <= 1'b0;
         wea2_q    <= 1'b0;
         addr_a_q  <= '1;
         addr_a2_q <= '1;
         cw_q      <= '0;
         ww_q      <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wea_q     <= wea_d;
         wea2_q    <= wea2_d;
         addr_a_q  <= addr_a_d;
         addr_a2_q <= addr_a2_d;
         cw_q      <= cw_d;
         ww_q      <= ww_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_tm_model_loader.sv
// Bench for tm_model_loader: randomized model streams, queue scoreboard, negedge monitor.
module tb_tm_model_loader;

   localparam int CLAUSEN = 10;
   localparam int CLASSN  = 10;
   localparam int WPC     = 5;
   localparam int DW      = 256;
   localparam int NW      = CLASSN * WPC;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [8:0]    clauses;
   logic          wea, wea2, busy, load_done, err;
   logic [31:0]   bram_addr_a, bram_addr_a2;
   logic [DW-1:0] clause_write, weight_write;

   tm_model_loader_if #(.DATA_W(DW)) s_if ();

   tm_model_loader #(
      .CLAUSEN (CLAUSEN),
      .CLASSN  (CLASSN),
      .WPC     (WPC),
      .DATA_W  (DW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .clauses      (clauses),
      .s            (s_if),
      .wea          (wea),
      .bram_addr_a  (bram_addr_a),
      .clause_write (clause_write),
      .wea2         (wea2),
      .bram_addr_a2 (bram_addr_a2),
      .weight_write (weight_write),
      .busy         (busy),
      .load_done    (load_done),
      .err          (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            kind;   // 0 clause write, 1 weight write, 2 load_done
      int            addr;
      logic [DW-1:0] data;
   } rec_t;

   rec_t          expq[$];
   int            pass_cnt = 0;
   int            total_cnt = 0;
   int            done_cyc = -1;
   bit            mon_en = 1'b0;
   logic [DW-1:0] last_cw = '0;
   logic [DW-1:0] last_ww = '0;

   task automatic chk(input bit ok, input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: pops the scoreboard on every strobe, checks idle outputs otherwise.
   always @(negedge clk) begin
      rec_t r;
      if (mon_en) begin
         chk(!(wea && wea2), "one_strobe", {wea, wea2}, 2'b00);
         if (wea) begin
            if (expq.size() == 0) chk(1'b0, "unexpected_wea", bram_addr_a, '1);
            else begin
               r = expq.pop_front();
               chk(r.kind == 0 && bram_addr_a == 32'(r.addr) && clause_write == r.data,
                   "clause_write", {bram_addr_a, clause_write[DW-33:0]},
                   {32'(r.addr), r.data[DW-33:0]});
               last_cw = r.data;
            end
         end else begin
            chk(bram_addr_a == '1 && clause_write == last_cw, "clause_idle",
                {bram_addr_a, clause_write[DW-33:0]}, {32'hFFFF_FFFF, last_cw[DW-33:0]});
         end
         if (wea2) begin
            if (expq.size() == 0) chk(1'b0, "unexpected_wea2", bram_addr_a2, '1);
            else begin
               r = expq.pop_front();
               chk(r.kind == 1 && bram_addr_a2 == 32'(r.addr) && weight_write == r.data,
                   "weight_write", {bram_addr_a2, weight_write[DW-33:0]},
                   {32'(r.addr), r.data[DW-33:0]});
               last_ww = r.data;
            end
         end else begin
            chk(bram_addr_a2 == '1 && weight_write == last_ww, "weight_idle",
                {bram_addr_a2, weight_write[DW-33:0]}, {32'hFFFF_FFFF, last_ww[DW-33:0]});
         end
         if (load_done) begin
            done_cyc = cyc;
            if (expq.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
            else begin
               r = expq.pop_front();
               chk(r.kind == 2, "load_done_order", 2, r.kind);
            end
         end
      end
   end

   task automatic check_reset_vals(input string name);
      chk({wea, wea2, load_done, err, busy, s_if.s_ready} == 6'b0, {name, "_ctrl"},
          {wea, wea2, load_done, err, busy, s_if.s_ready}, 6'b0);
      chk(bram_addr_a == '1 && bram_addr_a2 == '1, {name, "_addr"},
          {bram_addr_a, bram_addr_a2}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
      chk((clause_write | weight_write) == '0, {name, "_data"}, clause_write | weight_write, '0);
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int unsigned j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom;
      return w;
   endfunction

   // One load attempt: n clause words then weights; s_last at beat last_at (-1 none),
   // reset applied instead of beat rst_at (-1 none); stall = percent chance of idle cycles.
   task automatic run_load(input int n, input int last_at, input int rst_at, input int stall);
      int            total;
      int            m;
      bit            do_rst;
      bit            exp_ok;
      int            start_c;
      int            wait_c;
      int            guard;
      bit            rdy;
      logic [DW-1:0] d;
      rec_t          r;
      total  = n + NW;
      m      = (last_at >= 0 && last_at < total) ? last_at + 1 : total;
      do_rst = 1'b0;
      if (rst_at >= 0 && rst_at < m) begin
         m      = rst_at;
         do_rst = 1'b1;
      end
      exp_ok   = !do_rst && (last_at == total - 1);
      done_cyc = -1;

      start   = 1'b1;
      clauses = 9'(n);
      @(posedge clk); #1;
      start   = 1'b0;
      start_c = cyc;

      for (int i = 0; i < m; i++) begin
         guard = 0;
         while (stall > 0 && $urandom_range(99) < stall && guard < 8) begin
            s_if.s_valid = 1'b0;
            @(posedge clk); #1;
            guard++;
         end
         d = rand_word();
         s_if.s_data  = d;
         s_if.s_last  = (i == last_at);
         s_if.s_valid = 1'b1;
         r.kind = (i < n) ? 0 : 1;
         r.addr = (i < n) ? i : i - n;
         r.data = d;
         expq.push_back(r);
         wait_c = 0;
         do begin
            @(negedge clk);
            rdy = s_if.s_ready;
            if (i == 0 && wait_c == 0 && stall == 0)
               chk(rdy == 1'b1 && busy == 1'b1, "ready_after_start", {rdy, busy}, 2'b11);
            @(posedge clk); #1;
            wait_c++;
         end while (!rdy && wait_c < 100);
         if (!rdy) begin
            chk(1'b0, "accept_timeout", i, 0);
            break;
         end
      end
      s_if.s_valid = 1'b0;
      s_if.s_last  = 1'b0;
      if (exp_ok) begin
         r.kind = 2;
         r.addr = 0;
         r.data = '0;
         expq.push_back(r);
      end

      if (do_rst) begin
         reset = 1'b1;
         @(posedge clk); #1;
         last_cw = '0;
         last_ww = '0;
         @(negedge clk);
         check_reset_vals("reset_mid_load");
         reset = 1'b0;
         chk(expq.size() == 0, "reset_queue", expq.size(), 0);
      end else begin
         repeat (4) @(posedge clk);
         @(negedge clk);
         chk(expq.size() == 0, "queue_drained", expq.size(), 0);
         if (exp_ok) begin
            chk({err, busy, s_if.s_ready} == 3'b000, "end_ok", {err, busy, s_if.s_ready}, 3'b000);
            if (stall == 0)
               chk(done_cyc - start_c == n + NW + 1, "load_time", done_cyc - start_c, n + NW + 1);
         end else begin
            chk({err, busy, s_if.s_ready, load_done} == 4'b1000, "end_err",
                {err, busy, s_if.s_ready, load_done}, 4'b1000);
         end
      end
      expq.delete();
      @(posedge clk); #1;
   endtask

   task automatic bad_start(input int n);
      start   = 1'b1;
      clauses = 9'(n);
      @(posedge clk); #1;
      start   = 1'b0;
      @(negedge clk);
      chk({err, s_if.s_ready, busy} == 3'b100, "bad_count", {err, s_if.s_ready, busy}, 3'b100);
      @(posedge clk); #1;
      @(negedge clk);
      chk({err, s_if.s_ready} == 2'b10, "bad_count_hold", {err, s_if.s_ready}, 2'b10);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      int la;
      reset        = 1'b1;
      start        = 1'b0;
      clauses      = '0;
      s_if.s_valid = 1'b0;
      s_if.s_last  = 1'b0;
      s_if.s_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_vals("reset");
      mon_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_load(3, 3 + NW - 1, -1, 0);        // nominal
      run_load(3, 3 + NW - 1, -1, 50);       // stalls
      bad_start(0);
      bad_start(11);
      run_load(2, 2 + NW - 1, -1, 0);        // recovery from ERR
      run_load(3, 3 + 9, -1, 0);             // early s_last on weight addr 9
      run_load(3, -1, -1, 0);                // missing s_last
      run_load(3, 3 + NW - 1, 3 + 19, 0);    // reset during weight beat 20
      run_load(3, 3 + NW - 1, -1, 0);        // fresh load after reset
      run_load(CLAUSEN, CLAUSEN + NW - 1, -1, 30);
      run_load(1, NW, -1, 30);
      run_load(2, 1, -1, 0);                 // s_last on final clause beat
      for (int t = 0; t < 5; t++) begin
         n  = $urandom_range(CLAUSEN, 1);
         la = ($urandom_range(1) == 0) ? n + NW - 1 : $urandom_range(n + NW - 1, 0);
         run_load(n, la, -1, $urandom_range(60, 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
